// File: rtl/dcache_pkg.sv
// Shared types and constants for the data-cache controller.
// Geometry: 8 lines x 4-byte blocks, 8-bit CPU byte address, 32-bit memory block bus.
// CPU address layout: {tag, index, offset}. Memory block address layout: {tag, index}.
package dcache_pkg;

  localparam int unsigned NUM_LINES   = 8;
  localparam int unsigned BLOCK_BYTES = 4;
  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned IDX_W       = $clog2(NUM_LINES);
  localparam int unsigned OFF_W       = $clog2(BLOCK_BYTES);
  localparam int unsigned TAG_W       = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned BLOCK_W     = BLOCK_BYTES * DATA_W;
  localparam int unsigned BLK_ADDR_W  = TAG_W + IDX_W;

  // Controller states
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE      = 2'd0;
  localparam state_t S_WRITEBACK = 2'd1;
  localparam state_t S_FETCH     = 2'd2;
  localparam state_t S_UPDATE    = 2'd3;

  // CPU byte address split into its fields
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;
  } cpu_addr_t;

  // Block address presented to data memory
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
  } blk_addr_t;

  // Select one byte of a block; byte 0 lives in bits [7:0]
  function automatic logic [DATA_W-1:0] block_byte(input logic [BLOCK_W-1:0] blk,
                                                   input logic [OFF_W-1:0]   off);
    return blk[{off, 3'b000} +: DATA_W];
  endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// Bus bundle for the data cache: CPU request/response side plus memory block side.
//   CPU side   : READ, WRITE, ADDRESS, WRITEDATA -> cache ; READDATA, BUSYWAIT -> CPU
//   Memory side: MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA -> memory ;
//                MEM_READDATA, MEM_BUSYWAIT -> cache
// Modports: master = environment (CPU and data memory), slave = cache controller.
interface dcache_ctrl_if;
  import dcache_pkg::*;

  logic                  READ;
  logic                  WRITE;
  logic [ADDR_W-1:0]     ADDRESS;
  logic [DATA_W-1:0]     WRITEDATA;
  logic [DATA_W-1:0]     READDATA;
  logic                  BUSYWAIT;

  logic                  MEM_READ;
  logic                  MEM_WRITE;
  logic [BLK_ADDR_W-1:0] MEM_ADDRESS;
  logic [BLOCK_W-1:0]    MEM_WRITEDATA;
  logic [BLOCK_W-1:0]    MEM_READDATA;
  logic                  MEM_BUSYWAIT;

  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA,
    input  READDATA, BUSYWAIT,
    input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
    output MEM_READDATA, MEM_BUSYWAIT
  );

  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA,
    output READDATA, BUSYWAIT,
    output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
    input  MEM_READDATA, MEM_BUSYWAIT
  );

endinterface

// File: rtl/dcache_line_array.sv
// Line storage for the direct-mapped cache: valid/dirty flags, tags and data blocks.
// Ports:
//   clk, rst_n                      clock, async active-low clear of valid/dirty
//   rd_idx -> rd_valid/dirty/tag/block   combinational read of one line
//   wr_en, wr_idx, wr_off, wr_byte  synchronous CPU byte write (marks line dirty)
//   fill_en, fill_idx, fill_tag, fill_block  synchronous block fill (valid, clean)
// Tag and data arrays are intentionally not reset.
module dcache_line_array
  import dcache_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [BLOCK_W-1:0] rd_block,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [OFF_W-1:0]   wr_off,
  input  logic [DATA_W-1:0]  wr_byte,
  input  logic               fill_en,
  input  logic [IDX_W-1:0]   fill_idx,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [BLOCK_W-1:0] fill_block
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [BLOCK_W-1:0]   data_q [NUM_LINES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_block = data_q[rd_idx];

  // Line state flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
      dirty_q[fill_idx] <= 1'b0;
    end else if (wr_en) begin
      dirty_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data storage
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= fill_block;
    end else if (wr_en) begin
      data_q[wr_idx][{wr_off, 3'b000} +: DATA_W] <= wr_byte;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller for the 8-bit CPU.
// Ports:
//   CLK                 system clock, rising edge
//   RESET               asynchronous active-low reset
//   bus (slave)         CPU request/response and memory block handshake signals
//   HIT_COUNT, MISS_COUNT  16-bit saturating statistics (only with DCACHE_STATS_EN)
// Optional feature macro: DCACHE_STATS_EN.
// Hits are zero-stall: READDATA and BUSYWAIT are decoded combinationally from the
// current request. Misses walk IDLE -> [WRITEBACK] -> FETCH -> UPDATE -> IDLE and the
// held request then completes as a hit.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic         CLK,
  input  logic         RESET,
  dcache_ctrl_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]  HIT_COUNT,
  output logic [15:0]  MISS_COUNT
`endif
);

  state_t             state_q;
  state_t             state_d;
  logic               hs_seen_q;
  blk_addr_t          miss_blk_q;
  logic [BLOCK_W-1:0] fill_block_q;
  logic [DATA_W-1:0]  readdata_q;

  cpu_addr_t          req_addr;
  logic               req;
  logic               lookup;
  logic               hit;
  logic               rd_hit;
  logic               wr_hit;
  logic               miss;
  logic               hs_done;

  logic [IDX_W-1:0]   rd_idx;
  logic               rd_valid;
  logic               rd_dirty;
  logic [TAG_W-1:0]   rd_tag;
  logic [BLOCK_W-1:0] rd_block;
  logic [DATA_W-1:0]  hit_byte;

  logic               busy;
  logic               mem_read;
  logic               mem_write;
  blk_addr_t          mem_addr;
  logic [BLOCK_W-1:0] mem_wdata;
  logic               fill_en;

  // Request decode; requests are ignored while reset is asserted so outputs stay quiet
  assign req_addr = cpu_addr_t'(bus.ADDRESS);
  assign req      = (bus.READ | bus.WRITE) & RESET;
  assign lookup   = (state_q == S_IDLE) & req;
  assign hit      = rd_valid & (rd_tag == req_addr.tag);
  assign wr_hit   = lookup & hit & bus.WRITE;
  assign rd_hit   = lookup & hit & ~bus.WRITE;
  assign miss     = lookup & ~hit;

  // A memory transfer finishes once busy has been seen and then drops
  assign hs_done  = hs_seen_q & ~bus.MEM_BUSYWAIT;

  // In IDLE look up the live request; during a miss keep pointing at the victim line
  assign rd_idx   = (state_q == S_IDLE) ? req_addr.idx : miss_blk_q.idx;
  assign hit_byte = block_byte(rd_block, req_addr.off);

  dcache_line_array u_lines (
    .clk        (CLK),
    .rst_n      (RESET),
    .rd_idx     (rd_idx),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .rd_tag     (rd_tag),
    .rd_block   (rd_block),
    .wr_en      (wr_hit),
    .wr_idx     (req_addr.idx),
    .wr_off     (req_addr.off),
    .wr_byte    (bus.WRITEDATA),
    .fill_en    (fill_en),
    .fill_idx   (miss_blk_q.idx),
    .fill_tag   (miss_blk_q.tag),
    .fill_block (fill_block_q)
  );

  // Next state and memory-side outputs
  always_comb begin
    state_d   = state_q;
    busy      = miss;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    fill_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (miss) state_d = (rd_valid & rd_dirty) ? S_WRITEBACK : S_FETCH;
      end
      S_WRITEBACK: begin
        busy      = 1'b1;
        mem_write = 1'b1;
        mem_addr  = {rd_tag, miss_blk_q.idx};
        mem_wdata = rd_block;
        if (hs_done) state_d = S_FETCH;
      end
      S_FETCH: begin
        busy     = 1'b1;
        mem_read = 1'b1;
        mem_addr = miss_blk_q;
        if (hs_done) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        busy    = 1'b1;
        fill_en = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.BUSYWAIT      = busy;
  assign bus.READDATA      = rd_hit ? hit_byte : readdata_q;
  assign bus.MEM_READ      = mem_read;
  assign bus.MEM_WRITE     = mem_write;
  assign bus.MEM_ADDRESS   = mem_addr;
  assign bus.MEM_WRITEDATA = mem_wdata;

  // State, handshake flag, miss address and fill capture
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= S_IDLE;
      hs_seen_q    <= 1'b0;
      miss_blk_q   <= '0;
      fill_block_q <= '0;
      readdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (miss) miss_blk_q <= {req_addr.tag, req_addr.idx};
      // Flag restarts with every state change so each transfer needs its own busy phase
      if (state_d != state_q) begin
        hs_seen_q <= 1'b0;
      end else if (((state_q == S_WRITEBACK) || (state_q == S_FETCH)) && bus.MEM_BUSYWAIT) begin
        hs_seen_q <= 1'b1;
      end
      if ((state_q == S_FETCH) && hs_done) fill_block_q <= bus.MEM_READDATA;
      if (rd_hit) readdata_q <= hit_byte;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        refill_q;
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;

  // The lookup right after a fill is the tail of a miss, not a first-lookup hit
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      refill_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      refill_q <= (state_q == S_UPDATE);
      if (lookup && hit && !refill_q && (hit_cnt_q != 16'hFFFF)) hit_cnt_q <= hit_cnt_q + 16'd1;
      if (miss && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl with a behavioural block memory that
// holds MEM_BUSYWAIT high for a fixed number of cycles per transfer.
module tb_dcache_ctrl;

  localparam int MEM_LAT = 5;

  logic CLK;
  logic RESET;
  int   n_checks;
  int   n_fail;

  logic [31:0] mem_model [64];
  int          mem_cnt;

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  dcache_ctrl_if bus ();

  dcache_ctrl dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
`ifdef DCACHE_STATS_EN
    ,
    .HIT_COUNT  (hit_count),
    .MISS_COUNT (miss_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Block memory: busy for MEM_LAT cycles, then completes the transfer for one cycle
  initial begin
    for (int i = 0; i < 64; i++) mem_model[i] = 32'h0;
    mem_model[6'h09] = 32'hDDCCBBAA;
    mem_model[6'h29] = 32'h11223344;
    mem_model[6'h11] = 32'h55667788;
    mem_model[6'h12] = 32'hCAFEF00D;
    bus.MEM_BUSYWAIT = 1'b0;
    bus.MEM_READDATA = 32'h0;
    mem_cnt = 0;
    forever begin
      @(negedge CLK);
      if (!RESET || !(bus.MEM_READ || bus.MEM_WRITE)) begin
        bus.MEM_BUSYWAIT = 1'b0;
        mem_cnt = 0;
      end else if (mem_cnt < MEM_LAT) begin
        bus.MEM_BUSYWAIT = 1'b1;
        mem_cnt++;
      end else begin
        bus.MEM_BUSYWAIT = 1'b0;
        mem_cnt = 0;
        if (bus.MEM_WRITE) mem_model[bus.MEM_ADDRESS] = bus.MEM_WRITEDATA;
        else               bus.MEM_READDATA = mem_model[bus.MEM_ADDRESS];
      end
    end
  end

  // Safety net in case the main sequence stalls
  initial begin
    #100000;
    $display("FAIL watchdog: observed simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cycle();
    @(negedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Follow a miss until BUSYWAIT drops; n counts the stalled cycles including the first
  task automatic run_miss(output int n, output bit tmo,
                          output bit wr_seen, output logic [5:0] wr_a, output logic [31:0] wr_d,
                          output bit rd_seen, output logic [5:0] rd_a);
    n = 1; tmo = 1'b1;
    wr_seen = 1'b0; wr_a = '0; wr_d = '0;
    rd_seen = 1'b0; rd_a = '0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (!bus.BUSYWAIT) begin
        tmo = 1'b0;
        break;
      end
      n++;
      if (bus.MEM_WRITE && !wr_seen) begin
        wr_seen = 1'b1; wr_a = bus.MEM_ADDRESS; wr_d = bus.MEM_WRITEDATA;
      end
      if (bus.MEM_READ && !rd_seen) begin
        rd_seen = 1'b1; rd_a = bus.MEM_ADDRESS;
      end
    end
  endtask

  int          n;
  bit          tmo, wr_seen, rd_seen;
  logic [5:0]  wr_a, rd_a;
  logic [31:0] wr_d;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RESET = 1'b0;
    bus.READ = 1'b0; bus.WRITE = 1'b0; bus.ADDRESS = 8'h00; bus.WRITEDATA = 8'h00;

    // Reset state
    cycle(); cycle();
    chk("rst_busywait",  32'(bus.BUSYWAIT), 32'h0);
    chk("rst_mem_read",  32'(bus.MEM_READ), 32'h0);
    chk("rst_mem_write", 32'(bus.MEM_WRITE), 32'h0);
    chk("rst_mem_addr",  32'(bus.MEM_ADDRESS), 32'h0);
    chk("rst_mem_wdata", bus.MEM_WRITEDATA, 32'h0);
    chk("rst_readdata",  32'(bus.READDATA), 32'h0);
    cycle(); RESET = 1'b1; #1;
    chk("idle_busywait", 32'(bus.BUSYWAIT), 32'h0);

    // Cold read miss of 0x25: clean fetch of block 0x09, byte 1
    cycle(); bus.READ = 1'b1; bus.ADDRESS = 8'h25; #1;
    chk("cold_busy_now", 32'(bus.BUSYWAIT), 32'h1);
    run_miss(n, tmo, wr_seen, wr_a, wr_d, rd_seen, rd_a);
    chk("cold_timeout", 32'(tmo), 32'h0);
    chk("cold_no_wb", 32'(wr_seen), 32'h0);
    chk("cold_fetch_seen", 32'(rd_seen), 32'h1);
    chk("cold_fetch_addr", 32'(rd_a), 32'h09);
    chk("cold_latency", 32'(n), 32'd8);
    #1; chk("cold_readdata", 32'(bus.READDATA), 32'hBB);

    // No request: READDATA holds
    cycle(); bus.READ = 1'b0; #1;
    chk("hold_readdata", 32'(bus.READDATA), 32'hBB);
    chk("hold_busywait", 32'(bus.BUSYWAIT), 32'h0);

    // Read hit on the same block, byte 0
    cycle(); bus.READ = 1'b1; bus.ADDRESS = 8'h24; #1;
    chk("hit24_busy", 32'(bus.BUSYWAIT), 32'h0);
    chk("hit24_data", 32'(bus.READDATA), 32'hAA);

    // Write hit byte 3, then read it back
    cycle(); bus.READ = 1'b0; bus.WRITE = 1'b1; bus.ADDRESS = 8'h27; bus.WRITEDATA = 8'h5A; #1;
    chk("wr27_busy", 32'(bus.BUSYWAIT), 32'h0);
    chk("wr27_no_mem_write", 32'(bus.MEM_WRITE), 32'h0);
    chk("wr27_no_mem_read", 32'(bus.MEM_READ), 32'h0);
    cycle(); bus.WRITE = 1'b0; bus.READ = 1'b1; bus.ADDRESS = 8'h27; #1;
    chk("rd27_busy", 32'(bus.BUSYWAIT), 32'h0);
    chk("rd27_data", 32'(bus.READDATA), 32'h5A);

    // Dirty eviction: 0xA4 maps to line 1 with tag 5
    cycle(); bus.ADDRESS = 8'hA4; #1;
    chk("dirty_busy_now", 32'(bus.BUSYWAIT), 32'h1);
    run_miss(n, tmo, wr_seen, wr_a, wr_d, rd_seen, rd_a);
    chk("dirty_timeout", 32'(tmo), 32'h0);
    chk("dirty_wb_seen", 32'(wr_seen), 32'h1);
    chk("dirty_wb_addr", 32'(wr_a), 32'h09);
    chk("dirty_wb_data", wr_d, 32'h5ACCBBAA);
    chk("dirty_fetch_addr", 32'(rd_a), 32'h29);
    chk("dirty_latency", 32'(n), 32'd14);
    #1; chk("dirty_readdata", 32'(bus.READDATA), 32'h44);

    // Clean eviction: 0x44 maps to line 1 with tag 2, line is clean
    cycle(); bus.ADDRESS = 8'h44; #1;
    chk("clean_busy_now", 32'(bus.BUSYWAIT), 32'h1);
    run_miss(n, tmo, wr_seen, wr_a, wr_d, rd_seen, rd_a);
    chk("clean_timeout", 32'(tmo), 32'h0);
    chk("clean_no_wb", 32'(wr_seen), 32'h0);
    chk("clean_fetch_addr", 32'(rd_a), 32'h11);
    chk("clean_latency", 32'(n), 32'd8);
    #1; chk("clean_readdata", 32'(bus.READDATA), 32'h88);

`ifdef DCACHE_STATS_EN
    chk("stats_miss_pre", 32'(miss_count), 32'd3);
    chk("stats_hit_pre", 32'(hit_count), 32'd3);
`endif

    // Reset asserted in the middle of a fetch for 0x48
    cycle(); bus.ADDRESS = 8'h48; #1;
    cycle(); cycle(); cycle();
    chk("midrst_fetching", 32'(bus.MEM_READ), 32'h1);
    #2; RESET = 1'b0; #1;
    chk("midrst_mem_read", 32'(bus.MEM_READ), 32'h0);
    chk("midrst_busywait", 32'(bus.BUSYWAIT), 32'h0);
    chk("midrst_mem_addr", 32'(bus.MEM_ADDRESS), 32'h0);

    // After reset the previously installed 0x44 must miss again
    cycle(); RESET = 1'b1; bus.ADDRESS = 8'h44; #1;
    chk("postrst_busy_now", 32'(bus.BUSYWAIT), 32'h1);
    run_miss(n, tmo, wr_seen, wr_a, wr_d, rd_seen, rd_a);
    chk("postrst_timeout", 32'(tmo), 32'h0);
    chk("postrst_no_wb", 32'(wr_seen), 32'h0);
    chk("postrst_fetch_addr", 32'(rd_a), 32'h11);
    chk("postrst_latency", 32'(n), 32'd8);
    #1; chk("postrst_readdata", 32'(bus.READDATA), 32'h88);

    // Request dropped mid-miss: the fill still installs the line
    cycle(); bus.ADDRESS = 8'h48; #1;
    chk("drop_busy_now", 32'(bus.BUSYWAIT), 32'h1);
    cycle(); cycle(); cycle(); bus.READ = 1'b0; #1;
    chk("drop_still_fetching", 32'(bus.MEM_READ), 32'h1);
    tmo = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (!bus.BUSYWAIT) begin
        tmo = 1'b0;
        break;
      end
    end
    chk("drop_timeout", 32'(tmo), 32'h0);
    cycle(); bus.READ = 1'b1; bus.ADDRESS = 8'h48; #1;
    chk("drop_hit_busy", 32'(bus.BUSYWAIT), 32'h0);
    chk("drop_hit_data", 32'(bus.READDATA), 32'h0D);
    chk("drop_hit_no_fetch", 32'(bus.MEM_READ), 32'h0);

    cycle(); bus.READ = 1'b0; #1;
`ifdef DCACHE_STATS_EN
    chk("stats_miss_post", 32'(miss_count), 32'd2);
    chk("stats_hit_post", 32'(hit_count), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Data-side responder for the 8-bit CPU's memory port. It receives READ/WRITE/ADDRESS/WRITEDATA and returns READDATA/BUSYWAIT.
- Direct-mapped, write-back, write-allocate cache: 8 lines × 4-byte blocks.
- Sits between the CPU and the 32-bit-block data memory and drives the memory-side strobe/busywait handshake.

Parameters:
- NUM_LINES, 8, cache lines (power of 2; index width = log2).
- BLOCK_BYTES, 4, bytes per block (fixed; block bus = 32 bits).
- ADDR_W, 8, CPU byte-address width. Tag = ADDR_W − 2 − log2(NUM_LINES).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- READ  in  1  CPU load request.
- WRITE  in  1  CPU store request.
- ADDRESS  in  8  CPU byte address: [7:5] tag, [4:2] index, [1:0] byte offset.
- WRITEDATA  in  8  CPU store byte.
- READDATA  out  8  CPU load byte.
- BUSYWAIT  out  1  CPU stall; CPU holds request stable while high.
- MEM_READ  out  1  block fetch strobe.
- MEM_WRITE  out  1  block write-back strobe.
- MEM_ADDRESS  out  6  block address {tag, index}.
- MEM_WRITEDATA  out  32  write-back block, byte0 in [7:0].
- MEM_READDATA  in  32  fetched block.
- MEM_BUSYWAIT  in  1  memory busy.

Behaviour:
- Reset (RESET=0, async): all valid and dirty bits cleared, state IDLE, handshake flag cleared. Outputs: BUSYWAIT=0, MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, READDATA=0. Data/tag arrays are not cleared.
- Hit = valid[index] & (tag[index]==ADDRESS[7:5]). Evaluated combinationally.
- Request = READ|WRITE. READ and WRITE both high is treated as WRITE.
- IDLE, read hit: READDATA = block[index][offset] combinationally, BUSYWAIT=0. Zero-stall; CPU samples at the next posedge.
- IDLE, write hit: BUSYWAIT=0. At the posedge, the selected byte is written and dirty[index] is set.
- IDLE, miss: BUSYWAIT=1 combinationally in the same cycle. At the posedge, go to WRITEBACK if valid&dirty for the victim, else FETCH.
- WRITEBACK:
  - Drive MEM_WRITE=1, MEM_ADDRESS={victim tag, index}, MEM_WRITEDATA=victim block.
  - Leave on the first posedge where MEM_BUSYWAIT=0 after it has been sampled 1 at least once in this state; then go to FETCH.
- FETCH:
  - Drive MEM_READ=1, MEM_ADDRESS={ADDRESS tag, index}.
  - Same exit rule as WRITEBACK; then go to UPDATE, capturing MEM_READDATA on that edge.
- UPDATE (1 cycle): write the captured block, tag, valid=1, dirty=0. Go to IDLE, where the request re-evaluates as a hit.
- BUSYWAIT is 1 in every non-IDLE state. Strobes and MEM_ADDRESS are held stable for the whole state.
- Latency, clean miss: 1 (IDLE) + memory handshake cycles + 1 (UPDATE); the hit completes in the following IDLE cycle.
- Latency, dirty miss: a full write-back handshake is added before FETCH.
- Request dropped mid-miss: the fill completes anyway and the line is installed; no CPU write is performed.
- Reset mid-miss: immediate abort, strobes fall asynchronously, all lines invalid. Dirty data is lost by design.
- No request in IDLE: BUSYWAIT=0, no state change, READDATA holds its last value.

Optional Feature:
- Macro DCACHE_STATS_EN.
- When defined: adds outputs HIT_COUNT (16) and MISS_COUNT (16), both reset to 0.
  - HIT_COUNT increments once per completed request that hit on first lookup.
  - MISS_COUNT increments once per IDLE→WRITEBACK/FETCH transition.
  - Counters saturate at 16'hFFFF.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package dcache_pkg:
  - state enum {IDLE, WRITEBACK, FETCH, UPDATE};
  - TAG_W, IDX_W, OFF_W and field-slice constants;
  - block width.
- Sub-module dcache_line_array: valid/dirty/tag/data storage.
  - Combinational read of one line.
  - Synchronous byte-write and whole-block fill ports.
  - Async clear of valid/dirty.
- FSM and hit logic stay in dcache_ctrl.

Test Plan:
- Cold read: after reset, READ ADDRESS=8'h25; memory returns 32'hDDCCBBAA after 5 busy cycles → MEM_READ with MEM_ADDRESS=6'h09. BUSYWAIT then clears and READDATA=8'hBB.
- Write hit: preload line 1 as above, WRITE ADDRESS=8'h27 WRITEDATA=8'h5A → BUSYWAIT stays 0, no memory strobe. A following READ 8'h27 returns 8'h5A.
- Dirty eviction: after the write-hit test, READ 8'hA4 (same index, tag 5) → MEM_WRITE with MEM_ADDRESS=6'h09 and MEM_WRITEDATA=32'h5ACCBBAA, then MEM_READ with MEM_ADDRESS=6'h29.
- Clean eviction: repeat with a clean line → no MEM_WRITE, direct FETCH.
- Reset mid-FETCH: pull RESET low during MEM_READ → MEM_READ and BUSYWAIT fall immediately. A subsequent READ of the earlier address misses.
- Stats (DCACHE_STATS_EN): the sequence of 3 misses and 2 hits → MISS_COUNT=3, HIT_COUNT=2.
